decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the five-stage pipelined RV32I core, and the producer end of the execute-stage interface. It decodes the instruction held in the IF/ID register, reads the 32x32 register file, and sign-extends the immediate. It registers everything into the ID/EX pipeline register. It also hosts the hazard unit, which generates the execute-stage forwarding selects and the fetch/decode stall and flush controls.

## Interface
Parameters: none (XLEN fixed at 32, 32 architectural registers).

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears the register file and the ID/EX register
- InstrD  in  32  instruction from the IF/ID register
- PCD, PCPlus4D  in  32 each  PC and PC+4 of InstrD
- PCSrcE  in  1  taken branch or jump resolved in execute
- RdM  in  5  destination register of the instruction in memory
- RegWriteM  in  1  write enable of the instruction in memory
- RdW  in  5  destination register of the instruction in writeback
- RegWriteW  in  1  write enable of the instruction in writeback
- ResultW  in  32  writeback data
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  out  32 each  ID/EX data fields
- RdE  out  5  ID/EX destination register
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  ID/EX control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- forwardA, forwardB  out  2 each  00 register value, 01 ResultW, 10 ALUResultM
- StallF, StallD, FlushD  out  1 each  fetch/decode hazard controls

## Operation
- **Decoding.** Decode uses opcode InstrD[6:0], funct3 InstrD[14:12], and funct7[5] InstrD[30].
  - lw (0000011): RegWrite, ALUSrc, ResultSrc=01, add.
  - sw (0100011): MemWrite, ALUSrc, add.
  - R-type (0110011): RegWrite. ALU op from funct3: 000 gives add, or sub when funct7[5]=1; 010 slt; 110 or; 111 and.
  - I-ALU (0010011): RegWrite, ALUSrc. ALU op as R-type, except funct3 000 is always add.
  - beq (1100011): Branch, sub.
  - jal (1101111): RegWrite, Jump, ResultSrc=10.
  - Any other opcode decodes to all-zero control (a bubble).
- **Immediate extension.** Every immediate is sign-extended from bit 31.
  - I: [31:20].
  - S: [31:25],[11:7].
  - B: [31],[7],[30:25],[11:8],0.
  - J: [31],[19:12],[20],[30:21],0.
  - R-type: ImmExt=0.
- **Register file.**
  - Read addresses are Rs1D=InstrD[19:15] and Rs2D=InstrD[24:20]. Reads are combinational.
  - Writes occur on the rising edge when RegWriteW=1 and RdW≠0.
  - x0 always reads 0.
  - Write-through: if RegWriteW=1, RdW≠0 and RdW equals a read address, that read returns ResultW in the same cycle.
- **ID/EX register.**
  - Holds all E outputs plus internal Rs1E and Rs2E.
  - FlushE = lwStall | PCSrcE. When FlushE=1 the register loads all zeros on the next edge.
- **Load-use stall.**
  - lwStall = ResultSrcE[0] & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
- **Forwarding.** forwardA uses Rs1E; forwardB uses Rs2E (same rule):
  - 10 if RegWriteM & RdM≠0 & RdM==Rs.
  - Otherwise 01 if RegWriteW & RdW≠0 & RdW==Rs.
  - Otherwise 00.
  - Memory stage has priority over writeback.

## Timing
- **Reset.** Reset is asynchronous. On reset assertion:
  - All E outputs go to 0 immediately.
  - All 32 registers clear to 0.
  - forwardA, forwardB, StallF, StallD and FlushD settle to 0, since they are derived from the cleared state.
- **Latency.** An instruction on InstrD in cycle n appears on the E outputs after the edge ending cycle n.
- **Combinational outputs.** forwardA, forwardB, StallF, StallD and FlushD are combinational and are valid in the same cycle as their inputs.
- **Stall.** lwStall holds for exactly one cycle per load-use pair. The dependent instruction stays on InstrD, and the next cycle sees RdE=0, so the stall releases.
- **Simultaneous events.**
  - lwStall and PCSrcE together: flush wins. The E register is zeroed, FlushD=1, and StallF/StallD still assert; fetch redirect is handled in fetch.
  - Register write and read of the same register in one cycle: write-through returns the new value.
- **Reset mid-operation.** In-flight instructions are discarded. After release, the first edge captures InstrD normally.

## Test plan
1. **Reset.** Run with random instructions, then pulse reset low mid-cycle → E outputs are 0 before the next edge; afterwards, reading x1 gives 0.
2. **R-type decode.** Write x1=5 and x2=7 through the W port, then InstrD=0x002081B3 (add x3,x1,x2) → next cycle RD1E=5, RD2E=7, RdE=3, RegWriteE=1, ALUControlE=000, ALUSrcE=0.
3. **Load-use.** 0x0000A283 (lw x5,0(x1)) followed by 0x00528333 (add x6,x5,x5) → StallF=StallD=1 for one cycle and a zero bubble is inserted into E. With the add in E and the lw in W (RegWriteW=1, RdW=5): forwardA=forwardB=01.
4. **MEM forwarding priority.** add x1 in M and a different write to x1 in W, with InstrE=sub x4,x1,x2 (0x40208233) → forwardA=10, forwardB=00, ALUControlE=001.
5. **Branch flush.** PCSrcE=1 for one cycle → FlushD=1, and after the next edge all E outputs are 0.
6. **Write-through and x0.**
   - RegWriteW=1, RdW=9, ResultW=0xDEADBEEF while InstrD reads x9 as rs1 → RD1E=0xDEADBEEF after the edge.
   - RdW=0 with ResultW=0x1234 → x0 still reads 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: control decode, immediate extension, register
// file, ID/EX pipeline register and the hazard unit (forwarding, stall, flush).
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic [31:0] ResultW,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] PCE,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1d, rs2d;
  logic [4:0]  Rs1E, Rs2E;

  logic        regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d;
  logic [1:0]  resultsrc_d;
  logic [2:0]  aluctl_d;
  logic [2:0]  alu_arith;
  logic        sub_en;
  logic [31:0] imm_d;
  logic [31:0] rd1_d, rd2_d;
  logic        lwstall, flushe;

  logic [31:0] rf [32];

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign rs1d     = InstrD[19:15];
  assign rs2d     = InstrD[24:20];

  // funct7[5] selects sub only for R-type; I-type funct3 000 is always addi
  assign sub_en = (opcode == OP_RTYPE) && funct7b5;

  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000:  alu_arith = sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  alu_arith = ALU_SLT;
      3'b110:  alu_arith = ALU_OR;
      3'b111:  alu_arith = ALU_AND;
      default: alu_arith = ALU_ADD;
    endcase
  end

  always_comb begin
    regwrite_d  = 1'b0;
    memwrite_d  = 1'b0;
    jump_d      = 1'b0;
    branch_d    = 1'b0;
    alusrc_d    = 1'b0;
    resultsrc_d = 2'b00;
    aluctl_d    = ALU_ADD;
    imm_d       = '0;
    case (opcode)
      OP_LOAD: begin
        regwrite_d  = 1'b1;
        alusrc_d    = 1'b1;
        resultsrc_d = 2'b01;
        imm_d       = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_STORE: begin
        memwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        imm_d      = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_RTYPE: begin
        regwrite_d = 1'b1;
        aluctl_d   = alu_arith;
      end
      OP_IALU: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        aluctl_d   = alu_arith;
        imm_d      = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_BRANCH: begin
        branch_d = 1'b1;
        aluctl_d = ALU_SUB;
        imm_d    = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        regwrite_d  = 1'b1;
        jump_d      = 1'b1;
        resultsrc_d = 2'b10;
        imm_d       = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWriteW && (RdW != '0)) begin
      rf[RdW] <= ResultW;
    end
  end

  // Write-through lets a same-cycle writeback reach the instruction being decoded
  always_comb begin
    if (rs1d == '0)                          rd1_d = '0;
    else if (RegWriteW && (RdW == rs1d))     rd1_d = ResultW;
    else                                     rd1_d = rf[rs1d];
    if (rs2d == '0)                          rd2_d = '0;
    else if (RegWriteW && (RdW == rs2d))     rd2_d = ResultW;
    else                                     rd2_d = rf[rs2d];
  end

  assign lwstall = ResultSrcE[0] && (RdE != '0) && ((RdE == rs1d) || (RdE == rs2d));
  assign flushe  = lwstall || PCSrcE;
  assign StallF  = lwstall;
  assign StallD  = lwstall;
  assign FlushD  = PCSrcE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      ImmExtE     <= '0;
      PCPlus4E    <= '0;
      RdE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
    end else if (flushe) begin
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      ImmExtE     <= '0;
      PCPlus4E    <= '0;
      RdE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
    end else begin
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      PCE         <= PCD;
      ImmExtE     <= imm_d;
      PCPlus4E    <= PCPlus4D;
      RdE         <= InstrD[11:7];
      Rs1E        <= rs1d;
      Rs2E        <= rs2d;
      RegWriteE   <= regwrite_d;
      MemWriteE   <= memwrite_d;
      JumpE       <= jump_d;
      BranchE     <= branch_d;
      ALUSrcE     <= alusrc_d;
      ResultSrcE  <= resultsrc_d;
      ALUControlE <= aluctl_d;
    end
  end

  // Memory stage takes priority over writeback
  always_comb begin
    forwardA = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      forwardA = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) forwardA = 2'b01;
    forwardB = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      forwardB = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) forwardB = 2'b01;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage against a behavioural model of
// the decode rules, register file contents and the ID/EX register.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        PCSrcE;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] ResultW;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  forwardA, forwardB;
  logic        StallF, StallD, FlushD;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultW(ResultW), .RD1E(RD1E), .RD2E(RD2E),
    .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .forwardA(forwardA), .forwardB(forwardB),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  alu;
  } e_t;

  int          checks = 0;
  int          errors = 0;
  e_t          me;
  logic [31:0] mrf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic e_t zero_e();
    e_t z;
    z = '{default: '0};
    return z;
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return mrf[a];
  endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic is_sub);
    case (f3)
      3'd0:    return is_sub ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic e_t decode_ref(input logic [31:0] i);
    e_t e;
    e = zero_e();
    e.rd1 = rdreg(i[19:15]);
    e.rd2 = rdreg(i[24:20]);
    e.pc  = PCD;
    e.pc4 = PCPlus4D;
    e.rd  = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    case (i[6:0])
      7'b0000011: begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.imm = 32'($signed(i[31:20])); end
      7'b0100011: begin e.mw = 1; e.as = 1; e.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'b0110011: begin e.rw = 1; e.alu = alu_ref(i[14:12], i[30]); end
      7'b0010011: begin e.rw = 1; e.as = 1; e.alu = alu_ref(i[14:12], 1'b0);
                        e.imm = 32'($signed(i[31:20])); end
      7'b1100011: begin e.b = 1; e.alu = 3'd1;
                        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'b1101111: begin e.rw = 1; e.j = 1; e.rs = 2'b10;
                        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_e();
    chk("RD1E", RD1E, me.rd1);
    chk("RD2E", RD2E, me.rd2);
    chk("PCE", PCE, me.pc);
    chk("ImmExtE", ImmExtE, me.imm);
    chk("PCPlus4E", PCPlus4E, me.pc4);
    chk("RdE", 32'(RdE), 32'(me.rd));
    chk("RegWriteE", 32'(RegWriteE), 32'(me.rw));
    chk("MemWriteE", 32'(MemWriteE), 32'(me.mw));
    chk("JumpE", 32'(JumpE), 32'(me.j));
    chk("BranchE", 32'(BranchE), 32'(me.b));
    chk("ALUSrcE", 32'(ALUSrcE), 32'(me.as));
    chk("ResultSrcE", 32'(ResultSrcE), 32'(me.rs));
    chk("ALUControlE", 32'(ALUControlE), 32'(me.alu));
  endtask

  // One clock: check combinational hazard outputs, advance the model, check E after the edge
  task automatic cycle();
    logic lw;
    e_t   nx;
    #1;
    lw = me.rs[0] && (me.rd != 0) && (me.rd == InstrD[19:15] || me.rd == InstrD[24:20]);
    chk("StallF", 32'(StallF), 32'(lw));
    chk("StallD", 32'(StallD), 32'(lw));
    chk("FlushD", 32'(FlushD), 32'(PCSrcE));
    chk("forwardA", 32'(forwardA), 32'(fwd_ref(me.rs1)));
    chk("forwardB", 32'(forwardB), 32'(fwd_ref(me.rs2)));
    nx = (lw || PCSrcE) ? zero_e() : decode_ref(InstrD);
    if (RegWriteW && RdW != 0) mrf[RdW] = ResultW;
    me = nx;
    @(posedge clk);
    #1;
    check_e();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] i;
    logic [2:0]  f3s [4];
    f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
    i = $urandom;
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0: i[6:0] = 7'b0000011;
      1: i[6:0] = 7'b0100011;
      2: begin i[6:0] = 7'b0110011; i[14:12] = f3s[$urandom_range(0, 3)]; end
      3: begin i[6:0] = 7'b0010011; i[14:12] = f3s[$urandom_range(0, 3)]; end
      4: i[6:0] = 7'b1100011;
      5: i[6:0] = 7'b1101111;
      default: i[6:0] = 7'b0001111;
    endcase
    return i;
  endfunction

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      InstrD    = gen_instr();
      PCD       = $urandom;
      PCPlus4D  = PCD + 32'd4;
      PCSrcE    = ($urandom_range(0, 7) == 0);
      RdM       = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom);
      RdW       = 5'($urandom_range(0, 7));
      RegWriteW = 1'($urandom);
      ResultW   = $urandom;
      cycle();
    end
  endtask

  task automatic quiet();
    PCSrcE = 0; RegWriteM = 0; RdM = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
    PCD = 32'h100; PCPlus4D = 32'h104;
  endtask

  initial begin
    reset = 0;
    InstrD = 0;
    quiet();
    me = zero_e();
    for (int r = 0; r < 32; r++) mrf[r] = '0;
    #3;
    check_e();
    chk("rst_StallF", 32'(StallF), 32'd0);
    chk("rst_fwdA", 32'(forwardA), 32'd0);
    @(posedge clk);
    #1;
    reset = 1;

    rand_cycles(80);

    // asynchronous reset pulse between edges
    quiet();
    #2;
    reset = 0;
    #1;
    me = zero_e();
    for (int r = 0; r < 32; r++) mrf[r] = '0;
    check_e();
    chk("midrst_StallF", 32'(StallF), 32'd0);
    chk("midrst_FlushD", 32'(FlushD), 32'd0);
    chk("midrst_fwdA", 32'(forwardA), 32'd0);
    chk("midrst_fwdB", 32'(forwardB), 32'd0);
    #1;
    reset = 1;
    InstrD = 32'h002081B3;
    cycle();
    chk("midrst_x1", RD1E, 32'd0);

    // R-type decode after register writes
    InstrD = 32'h0; RegWriteW = 1; RdW = 1; ResultW = 32'd5;
    cycle();
    RdW = 2; ResultW = 32'd7;
    cycle();
    RegWriteW = 0; InstrD = 32'h002081B3;
    cycle();
    chk("add_RD1E", RD1E, 32'd5);
    chk("add_RD2E", RD2E, 32'd7);
    chk("add_RdE", 32'(RdE), 32'd3);
    chk("add_RegWriteE", 32'(RegWriteE), 32'd1);
    chk("add_ALUControlE", 32'(ALUControlE), 32'd0);
    chk("add_ALUSrcE", 32'(ALUSrcE), 32'd0);

    // load-use stall and bubble
    InstrD = 32'h0000A283;
    cycle();
    InstrD = 32'h00528333;
    #1;
    chk("lu_StallF", 32'(StallF), 32'd1);
    chk("lu_StallD", 32'(StallD), 32'd1);
    cycle();
    chk("lu_bubble_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("lu_bubble_RdE", 32'(RdE), 32'd0);
    #1;
    chk("lu_release", 32'(StallF), 32'd0);
    cycle();
    chk("lu_add_RdE", 32'(RdE), 32'd6);
    InstrD = 32'h0; RegWriteW = 1; RdW = 5; ResultW = 32'h55;
    #1;
    chk("lu_fwdA", 32'(forwardA), 32'd1);
    chk("lu_fwdB", 32'(forwardB), 32'd1);
    cycle();

    // memory-stage forwarding priority
    RegWriteW = 0; InstrD = 32'h40208233;
    cycle();
    RegWriteM = 1; RdM = 1; RegWriteW = 1; RdW = 1; ResultW = 32'h99; InstrD = 32'h0;
    #1;
    chk("pri_fwdA", 32'(forwardA), 32'd2);
    chk("pri_fwdB", 32'(forwardB), 32'd0);
    chk("pri_ALUControlE", 32'(ALUControlE), 32'd1);
    cycle();

    // branch flush
    quiet();
    InstrD = 32'h002081B3; PCSrcE = 1;
    #1;
    chk("br_FlushD", 32'(FlushD), 32'd1);
    cycle();
    chk("br_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("br_PCE", PCE, 32'd0);
    chk("br_RD1E", RD1E, 32'd0);
    PCSrcE = 0;

    // write-through and x0
    RegWriteW = 1; RdW = 9; ResultW = 32'hDEADBEEF; InstrD = 32'h00048513;
    cycle();
    chk("wt_RD1E", RD1E, 32'hDEADBEEF);
    RdW = 0; ResultW = 32'h1234; InstrD = 32'h000005B3;
    cycle();
    chk("x0_RD1E", RD1E, 32'd0);
    chk("x0_RD2E", RD2E, 32'd0);
    RegWriteW = 0; InstrD = 32'h00048513;
    cycle();
    chk("x9_kept", RD1E, 32'hDEADBEEF);

    rand_cycles(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
